// File: rtl/spi_ebr_bridge_if.sv
// SPI pins plus the EBR single-port pins around spi_ebr_bridge.
// The bridge uses the slave modport; the MCU/RAM side uses master.
interface spi_ebr_bridge_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              spi_sclk_i;
    logic              spi_cs_n_i;
    logic              spi_mosi_i;
    logic              spi_miso_o;
    logic              spi_miso_oe_o;
    logic              ram_clk_en_o;
    logic              ram_wr_en_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wr_data_o;
    logic [DATA_W-1:0] ram_rd_data_i;
    logic              busy_o;
    logic              frame_err_o;

    modport slave (
        input  spi_sclk_i, spi_cs_n_i, spi_mosi_i, ram_rd_data_i,
        output spi_miso_o, spi_miso_oe_o, ram_clk_en_o, ram_wr_en_o,
               ram_addr_o, ram_wr_data_o, busy_o, frame_err_o
    );

    modport master (
        output spi_sclk_i, spi_cs_n_i, spi_mosi_i, ram_rd_data_i,
        input  spi_miso_o, spi_miso_oe_o, ram_clk_en_o, ram_wr_en_o,
               ram_addr_o, ram_wr_data_o, busy_o, frame_err_o
    );
endinterface

// File: rtl/spi_ebr_bridge.sv
// SPI mode-0 slave (MSB first) giving an MCU read/write access to a 256x16 EBR.
// Define SPI_EBR_BRIDGE_STATUS_EN to add the CMD 0x3C status read and write counter.
module spi_ebr_bridge #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    spi_ebr_bridge_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned BYTE_W = 8;
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
`ifdef SPI_EBR_BRIDGE_STATUS_EN
    localparam logic [BYTE_W-1:0] STAT_CMD = 8'h3C;
    localparam logic [BYTE_W-1:0] STAT_TAG = 8'hA5;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_STAT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    logic w_sclk;
    logic w_cs_n;
    logic w_mosi;
    logic w_rise;
    logic w_fall;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_tx_sh;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cmd_wr;
    logic              r_cap;

    logic              r_miso;
    logic              r_miso_oe;
    logic              r_ram_clk_en;
    logic              r_ram_wr_en;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wr_data;
    logic              r_busy;
    logic              r_frame_err;

`ifdef SPI_EBR_BRIDGE_STATUS_EN
    logic [BYTE_W-1:0] r_wr_cnt;
`endif

    logic [BYTE_W-1:0] w_rx_byte;
    logic [DATA_W-1:0] w_rx_word;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    assign w_rx_byte = {r_rx_sh[BYTE_W-2:0], w_mosi};
    assign w_rx_word = {r_rx_sh[DATA_W-2:0], w_mosi};

    // Pin synchronizers; CS idles deasserted so reset it high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
            r_sclk_d    <= w_sclk;
        end
    end

    // Frame FSM with registered RAM strobes and MISO.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rx_sh       <= '0;
            r_tx_sh       <= '0;
            r_addr        <= '0;
            r_cmd_wr      <= 1'b0;
            r_cap         <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_ram_clk_en  <= 1'b0;
            r_ram_wr_en   <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wr_data <= '0;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
`ifdef SPI_EBR_BRIDGE_STATUS_EN
            r_wr_cnt      <= '0;
`endif
        end else begin
            r_ram_clk_en <= 1'b0;
            r_ram_wr_en  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cap        <= r_ram_clk_en & ~r_ram_wr_en;
            r_busy       <= ~w_cs_n;
            r_miso_oe    <= ~w_cs_n;

            if (w_cs_n) begin
                // A non-zero bit count means the frame ended inside a byte or word.
                if ((r_state != S_IDLE) && (r_cnt != '0)) begin
                    r_frame_err <= 1'b1;
                end
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_rx_sh <= '0;
                r_tx_sh <= '0;
                r_miso  <= 1'b0;
                r_cap   <= 1'b0;
            end else begin
                if (w_rise && (r_state != S_IDLE)) begin
                    r_rx_sh <= w_rx_word;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        r_state <= S_CMD;
                        r_cnt   <= '0;
                        r_miso  <= 1'b0;
                    end

                    S_CMD: begin
                        if (w_rise && (r_cnt == BYTE_LAST)) begin
                            r_cnt    <= '0;
                            r_cmd_wr <= w_rx_byte[BYTE_W-1];
                            r_state  <= S_ADDR;
`ifdef SPI_EBR_BRIDGE_STATUS_EN
                            if (w_rx_byte == STAT_CMD) begin
                                r_state <= S_STAT;
                                r_tx_sh <= DATA_W'({STAT_TAG, r_wr_cnt});
                                r_miso  <= STAT_TAG[BYTE_W-1];
                            end
`endif
                        end
                    end

                    S_ADDR: begin
                        if (w_rise && (r_cnt == BYTE_LAST)) begin
                            r_cnt  <= '0;
                            r_addr <= ADDR_W'(w_rx_byte);
                            if (r_cmd_wr) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_state      <= S_RDATA;
                                r_ram_clk_en <= 1'b1;
                                r_ram_addr   <= ADDR_W'(w_rx_byte);
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_rise && (r_cnt == WORD_LAST)) begin
                            r_cnt         <= '0;
                            r_ram_clk_en  <= 1'b1;
                            r_ram_wr_en   <= 1'b1;
                            r_ram_addr    <= r_addr;
                            r_ram_wr_data <= w_rx_word;
                            r_addr        <= r_addr + ADDR_W'(1);
`ifdef SPI_EBR_BRIDGE_STATUS_EN
                            r_wr_cnt      <= r_wr_cnt + BYTE_W'(1);
`endif
                        end
                    end

                    S_RDATA: begin
                        // Prefetch the next word as soon as the current one is fully clocked.
                        if (w_rise && (r_cnt == WORD_LAST)) begin
                            r_cnt        <= '0;
                            r_ram_clk_en <= 1'b1;
                            r_ram_addr   <= r_addr;
                        end
                        if (w_fall && (r_cnt != '0)) begin
                            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                            r_miso  <= r_tx_sh[DATA_W-2];
                        end
                        if (r_cap) begin
                            r_tx_sh <= bus.ram_rd_data_i;
                            r_miso  <= bus.ram_rd_data_i[DATA_W-1];
                            r_addr  <= r_addr + ADDR_W'(1);
                        end
                    end

`ifdef SPI_EBR_BRIDGE_STATUS_EN
                    S_STAT: begin
                        if (w_rise && (r_cnt == WORD_LAST)) begin
                            r_cnt   <= '0;
                            r_tx_sh <= '0;
                            r_miso  <= 1'b0;
                        end else if (w_fall && (r_cnt != '0)) begin
                            r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                            r_miso  <= r_tx_sh[DATA_W-2];
                        end
                    end
`endif

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.spi_miso_o    = r_miso;
    assign bus.spi_miso_oe_o = r_miso_oe;
    assign bus.ram_clk_en_o  = r_ram_clk_en;
    assign bus.ram_wr_en_o   = r_ram_wr_en;
    assign bus.ram_addr_o    = r_ram_addr;
    assign bus.ram_wr_data_o = r_ram_wr_data;
    assign bus.busy_o        = r_busy;
    assign bus.frame_err_o   = r_frame_err;

endmodule

// File: tb/tb_spi_ebr_bridge.sv
// Directed bench for spi_ebr_bridge: bench acts as SPI master and as the EBR model.
// Status-read steps run only when SPI_EBR_BRIDGE_STATUS_EN is defined.
module tb_spi_ebr_bridge;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int          HALF   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_ebr_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spi_ebr_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // Synchronous single-port RAM model
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.ram_clk_en_o) begin
            if (bus.ram_wr_en_o) mem[bus.ram_addr_o] <= bus.ram_wr_data_o;
            else                 bus.ram_rd_data_i  <= mem[bus.ram_addr_o];
        end
    end

    // Strobe and error-pulse monitor
    int   wr_n = 0, rd_n = 0, err_n = 0, err_len = 0, err_last = 0, ce_dbl = 0;
    logic prev_ce = 1'b0;
    logic [ADDR_W-1:0] wa_log [0:63];
    logic [DATA_W-1:0] wd_log [0:63];
    always @(negedge clk) begin
        if (bus.ram_clk_en_o && bus.ram_wr_en_o) begin
            wa_log[wr_n % 64] = bus.ram_addr_o;
            wd_log[wr_n % 64] = bus.ram_wr_data_o;
            wr_n++;
        end else if (bus.ram_clk_en_o) begin
            rd_n++;
        end
        if (bus.ram_clk_en_o && prev_ce) ce_dbl++;
        prev_ce = bus.ram_clk_en_o;
        if (bus.frame_err_o) begin
            err_len++;
        end else if (err_len != 0) begin
            err_n++;
            err_last = err_len;
            err_len  = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [15:0] tx, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi_i = tx[i];
            repeat (HALF) @(negedge clk);
            bus.spi_sclk_i = 1'b1;
            rx = {rx[14:0], bus.spi_miso_o};
            repeat (HALF) @(negedge clk);
            bus.spi_sclk_i = 1'b0;
        end
    endtask

    task automatic cs_on();
        bus.spi_cs_n_i = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (HALF) @(negedge clk);
        bus.spi_cs_n_i = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return {bus.spi_miso_o, bus.spi_miso_oe_o, bus.ram_clk_en_o, bus.ram_wr_en_o,
                bus.busy_o, bus.frame_err_o, 2'b00, bus.ram_addr_o, bus.ram_wr_data_o};
    endfunction

    logic [15:0] rx;
    int wr0, rd0, err0;

    initial begin
        bus.spi_sclk_i    = 1'b0;
        bus.spi_cs_n_i    = 1'b1;
        bus.spi_mosi_i    = 1'b0;
        bus.ram_rd_data_i = '0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", outs(), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(bus.busy_o), 32'h0);

        // Two-word write at 0x10
        wr0 = wr_n; err0 = err_n;
        cs_on();
        spi_bits(16'h0080, 8, rx);
        chk("busy_in_frame", 32'({bus.busy_o, bus.spi_miso_oe_o}), 32'h3);
        spi_bits(16'h0010, 8, rx);
        spi_bits(16'hBEEF, 16, rx);
        spi_bits(16'h1234, 16, rx);
        cs_off();
        chk("wr_strobes", 32'(wr_n - wr0), 32'd2);
        chk("wr0_addr_data", {8'h0, wa_log[wr0 % 64], wd_log[wr0 % 64]}, 32'h0010_BEEF);
        chk("wr1_addr_data", {8'h0, wa_log[(wr0 + 1) % 64], wd_log[(wr0 + 1) % 64]}, 32'h0011_1234);
        chk("wr_no_err", 32'(err_n - err0), 32'd0);
        chk("busy_after", 32'({bus.busy_o, bus.spi_miso_oe_o}), 32'h0);

        // Streaming read from 0x10
        wr0 = wr_n; rd0 = rd_n;
        cs_on();
        spi_bits(16'h0000, 8, rx);
        chk("miso_cmd_zero", 32'(rx[7:0]), 32'h0);
        spi_bits(16'h0010, 8, rx);
        chk("miso_addr_zero", 32'(rx[7:0]), 32'h0);
        spi_bits(16'h0000, 16, rx);
        chk("rd_word0", 32'(rx), 32'h0000_BEEF);
        spi_bits(16'h0000, 16, rx);
        chk("rd_word1", 32'(rx), 32'h0000_1234);
        cs_off();
        chk("rd_strobes_2or3", 32'((rd_n - rd0) >= 2 && (rd_n - rd0) <= 3), 32'h1);
        chk("rd_no_write", 32'(wr_n - wr0), 32'd0);

        // Address wrap 0xFF -> 0x00
        wr0 = wr_n;
        cs_on();
        spi_bits(16'h0080, 8, rx);
        spi_bits(16'h00FF, 8, rx);
        spi_bits(16'h0001, 16, rx);
        spi_bits(16'h0002, 16, rx);
        cs_off();
        chk("wrap_strobes", 32'(wr_n - wr0), 32'd2);
        chk("wrap_w0", {8'h0, wa_log[wr0 % 64], wd_log[wr0 % 64]}, 32'h00FF_0001);
        chk("wrap_w1", {8'h0, wa_log[(wr0 + 1) % 64], wd_log[(wr0 + 1) % 64]}, 32'h0000_0002);

        // CS raised after 9 bits of a data word
        wr0 = wr_n; err0 = err_n;
        cs_on();
        spi_bits(16'h0080, 8, rx);
        spi_bits(16'h0020, 8, rx);
        spi_bits(16'h01FF, 9, rx);
        cs_off();
        chk("partial_no_write", 32'(wr_n - wr0), 32'd0);
        chk("partial_err_pulses", 32'(err_n - err0), 32'd1);
        chk("partial_err_len", 32'(err_last), 32'd1);
        chk("partial_busy", 32'(bus.busy_o), 32'h0);

        // Following frame works
        wr0 = wr_n; err0 = err_n;
        cs_on();
        spi_bits(16'h0080, 8, rx);
        spi_bits(16'h0021, 8, rx);
        spi_bits(16'h5A5A, 16, rx);
        cs_off();
        chk("recover_write", {8'h0, wa_log[wr0 % 64], wd_log[wr0 % 64]}, 32'h0021_5A5A);
        chk("recover_count_err", {16'(wr_n - wr0), 16'(err_n - err0)}, 32'h0001_0000);

        // CMD-only frame: clean; partial ADDR: error, no access
        wr0 = wr_n; rd0 = rd_n; err0 = err_n;
        cs_on();
        spi_bits(16'h0080, 8, rx);
        cs_off();
        chk("cmd_only_clean", {16'(wr_n - wr0 + rd_n - rd0), 16'(err_n - err0)}, 32'h0);
        cs_on();
        spi_bits(16'h0000, 8, rx);
        spi_bits(16'h0003, 4, rx);
        cs_off();
        chk("part_addr_err", {16'(wr_n - wr0 + rd_n - rd0), 16'(err_n - err0)}, 32'h0000_0001);

        // Reset mid-read
        cs_on();
        spi_bits(16'h0000, 8, rx);
        spi_bits(16'h0010, 8, rx);
        spi_bits(16'h0000, 5, rx);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 32'h0);
        bus.spi_cs_n_i = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wr0 = wr_n;
        cs_on();
        spi_bits(16'h0080, 8, rx);
        spi_bits(16'h0005, 8, rx);
        spi_bits(16'hCAFE, 16, rx);
        cs_off();
        chk("post_reset_write", {8'h0, wa_log[wr0 % 64], wd_log[wr0 % 64]}, 32'h0005_CAFE);
        chk("post_reset_count", 32'(wr_n - wr0), 32'd1);

`ifdef SPI_EBR_BRIDGE_STATUS_EN
        cs_on();
        spi_bits(16'h0080, 8, rx);
        spi_bits(16'h0040, 8, rx);
        spi_bits(16'h1111, 16, rx);
        spi_bits(16'h2222, 16, rx);
        cs_off();
        wr0 = wr_n; rd0 = rd_n;
        cs_on();
        spi_bits(16'h003C, 8, rx);
        spi_bits(16'h0000, 16, rx);
        chk("status_word", 32'(rx), 32'h0000_A503);
        spi_bits(16'h0000, 16, rx);
        chk("status_tail_zero", 32'(rx), 32'h0);
        cs_off();
        chk("status_no_ram", 32'(wr_n - wr0 + rd_n - rd0), 32'd0);
`endif

        chk("ce_never_double", 32'(ce_dbl), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_ebr_bridge.md
Name: spi_ebr_bridge

Overview:
- SPI slave (mode 0, MSB first) that lets the nRF MCU read and write the 256x16 EBR buffer through its single-port interface.
- Sits directly upstream of the EBR block and drives its clock-enable, write-enable, address and write-data pins; consumes its read data.
- SPI pins are oversampled in the system clock domain. Requirement: clk_i >= 8x SCLK.

Parameters:
- ADDR_W, 8, RAM address width; address wraps modulo 2^ADDR_W.
- DATA_W, 16, RAM word width; one SPI data word = DATA_W bits.
- SYNC_STAGES, 2, flip-flop synchronizer depth on SCLK, CS_N and MOSI.

Ports:
- clk_i  in  1  system clock; also the RAM clock.
- rst_i  in  1  asynchronous, active-low reset.
- spi_sclk_i  in  1  SPI clock from MCU, asynchronous.
- spi_cs_n_i  in  1  SPI chip select, active low.
- spi_mosi_i  in  1  SPI data from MCU.
- spi_miso_o  out  1  SPI data to MCU.
- spi_miso_oe_o  out  1  MISO output enable; high only while CS is asserted.
- ram_clk_en_o  out  1  RAM clock-enable strobe.
- ram_wr_en_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wr_data_o  out  DATA_W  RAM write data.
- ram_rd_data_i  in  DATA_W  RAM read data, valid the cycle after a read strobe.
- busy_o  out  1  high while a frame is in progress (CS asserted).
- frame_err_o  out  1  one-cycle pulse when CS deasserts mid-byte or mid-word.

Behaviour:
- Reset (rst_i low, asynchronous): all outputs 0, FSM in IDLE, shift registers and counters cleared, synchronizers cleared (CS synchronizer reset to 1).
- Edges: rising and falling SCLK edges are detected from the synchronized SCLK. MOSI is sampled on the detected rise. MISO advances on the detected fall.
- Frame format: CMD byte, ADDR byte, then N data words.
  - CMD[7]=1: write.
  - CMD[7]=0: read.
  - CMD[6:0] are ignored unless the optional feature is compiled in.
- FSM states: IDLE -> CMD (CS falls) -> ADDR (8 bits) -> WDATA or RDATA (8 bits) -> same state each word. Any state -> IDLE when CS rises.
- Write path:
  - Rise detect of bit 0 of a word occurs in cycle N.
  - Cycle N+1: ram_clk_en_o=1, ram_wr_en_o=1, ram_addr_o=current address, ram_wr_data_o=word. Single-cycle strobe.
  - Address increments after the strobe.
- Read path:
  - ADDR byte completes in cycle N.
  - Cycle N+1: ram_clk_en_o=1, ram_wr_en_o=0, ram_addr_o=A.
  - Cycle N+2: ram_rd_data_i is captured into the TX shifter; MISO drives bit 15 immediately; address increments.
  - The next word is prefetched the same way after the rise detect of bit 0 of the current word, giving unbroken streaming.
  - During the CMD and ADDR bytes, MISO drives 0.
- Wrap-around: address 0xFF increments to 0x00 with no error.
- CS deasserted on a word or byte boundary: clean end. No strobe, no error.
- CS deasserted mid-byte or mid-word:
  - The partial word is discarded and no RAM write occurs.
  - frame_err_o pulses for 1 cycle.
  - FSM returns to IDLE.
- Frame with CMD only, or with a partial ADDR byte: no RAM access; frame_err_o pulses only if the ADDR byte is partial.
- Reset mid-frame: immediate return to IDLE. Any pending strobe is dropped and nothing is written.
- ram_clk_en_o is never high for more than 1 consecutive cycle. Read and write strobes are never issued in the same cycle.

Optional Feature:
- Macro: SPI_EBR_BRIDGE_STATUS_EN.
- Defined:
  - CMD=0x3C is a status read. No ADDR byte follows; the next 16 bits on MISO are {8'hA5, wr_count[7:0]}, then MISO drives 0.
  - wr_count counts completed RAM writes, wraps at 256, and is cleared only by reset.
  - No RAM access occurs during a status frame.
- Not defined: 0x3C is an ordinary read command (CMD[7]=0), and no counter logic is built.

Test Plan:
- Write frame 0x80, 0x10, 0xBEEF, 0x1234 -> two single-cycle write strobes, addr 0x10 data 0xBEEF, then addr 0x11 data 0x1234; frame_err_o stays 0.
- Read frame 0x00, 0x10, then 32 SCLKs, with the RAM model preloaded -> MISO returns 0xBEEF then 0x1234; exactly 2 read strobes (plus at most 1 prefetch), wr_en never high.
- Write at 0xFF of 0x0001, 0x0002 -> writes land at 0xFF then 0x00.
- Write frame with CS raised after 9 bits of a data word -> no write strobe, frame_err_o high for exactly 1 cycle, busy_o falls; the next frame works normally.
- rst_i pulsed low mid-read -> all outputs 0 asynchronously; a subsequent write 0x80, 0x05, 0xCAFE -> address 0x05 written.
- With SPI_EBR_BRIDGE_STATUS_EN defined, after 3 writes send CMD 0x3C -> MISO returns 0xA503 and no RAM strobe occurs.
